octal_key_entry: RTL and testbench
==================================

Name: octal_key_entry

Overview:
- Input-side counterpart to the board's octal 7-segment display path.
- Reads the raw active-low KEY pushbuttons, synchronises and debounces them, and edits a 3-digit octal value one digit at a time.
- The 9-bit value uses the same packing the display path decodes from SW[8:0]: digit0 = [2:0], digit1 = [5:3], digit2 = [8:6].
- Also produces a blink mask so the display can flash the digit currently selected for editing.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: stable cycles required before a key level is accepted (20 ms at 50 MHz); minimum 2.
- BLINK_CYCLES, 12_500_000: half-period of the selected-digit blink (250 ms at 50 MHz); minimum 2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- key_inc_n  in  1  raw pushbutton, 0 = pressed; increments the selected digit.
- key_dec_n  in  1  raw pushbutton, 0 = pressed; decrements the selected digit.
- key_sel_n  in  1  raw pushbutton, 0 = pressed; advances the digit selection.
- load  in  1  synchronous strobe; copies load_value into the entry.
- load_value  in  9  value to load, in octal packing.
- value  out  9  current 3-digit octal value.
- sel  out  2  selected digit index, 0..2.
- blank_mask  out  3  1 = display should blank that digit this cycle.
- changed  out  1  one-cycle pulse when value or sel changes.

Behaviour:
- Reset (RESET_N low, asynchronous) forces:
  - value = 0, sel = 0, blank_mask = 0, changed = 0.
  - Debounce states = released; blink counter = 0; blink phase = 0.
- Synchroniser: each raw key passes through a 2-FF synchroniser. Its reset value is 1 (released).
- Debounce:
  - Per key, a counter runs while the synchronised level differs from the accepted level.
  - The accepted level flips when the counter reaches DEBOUNCE_CYCLES-1.
  - Any return to the accepted level clears the counter.
- Press event:
  - One-cycle pulse when the accepted level goes 1->0.
  - Release generates no event.
  - Holding a key produces no auto-repeat.
- Latency: a clean press gives its event 2 (sync) + DEBOUNCE_CYCLES cycles after the raw edge. value/sel update on the following clock edge.
- Priority within one cycle:
  1. load: value <= load_value, sel <= 0. All press events in that cycle are discarded.
  2. inc and dec together: they cancel, and the digit is unchanged.
  3. inc alone: digit[sel] <= digit[sel]+1 mod 8 (7 -> 0 wraps; no carry into the neighbouring digit).
  4. dec alone: digit[sel] <= digit[sel]-1 mod 8 (0 -> 7 wraps; no borrow).
  5. sel event: sel <= (sel==2) ? 0 : sel+1. Applied in the same cycle as an inc/dec, which acts on the old sel.
- changed: registered and asserted the cycle after value or sel differs from its previous value. A load of an identical value with sel already 0 gives no pulse.
- Blink:
  - Free-running counter wraps at BLINK_CYCLES-1 and toggles the blink phase.
  - blank_mask = phase ? (1<<sel) : 0.
  - Any sel event or load clears the counter and phase, so the newly selected digit is visible immediately.
- sel never takes the value 3. A defensive default maps it back to 0.
- Reset asserted mid-debounce or mid-blink: all state is discarded. After RESET_N is released, a key held low must be seen stable for DEBOUNCE_CYCLES before it is accepted; this produces exactly one event.

Decomposition:
- Shared package de1_pkg:
  - typedef octal_digit_t (logic [2:0]).
  - NUM_DIGITS = 3.
  - Function pack_octal / unpack_octal for the 9-bit packing.
- Sub-module key_debounce:
  - Contains the synchroniser, debounce counter and press-event pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated once per key.
- Top level holds the digit registers, sel, the event arbitration, the blink counter and changed.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
- Reset then idle 50 cycles -> value=0, sel=0, changed never asserted.
- key_inc_n low for 3 cycles (bounce), high 2, then low 20 -> exactly one event. After 9 total presses value=9'o001 (7->0 wrap seen). changed pulses once per press.
- From value=0, sel, sel, dec -> sel=2 and value=9'o700. A fourth sel -> sel=0.
- inc and dec pressed in the same cycle -> value unchanged, no changed pulse. sel with inc in the same cycle on sel=1 -> digit1 increments and sel becomes 2.
- load with load_value=9'o527 coincident with an inc event -> value=9'o527, sel=0, inc discarded. blank_mask=0 for 8 cycles, then 3'b001 for 8 cycles, then alternates.
- RESET_N pulsed low mid-debounce while key_inc_n is held low -> after release, one event arrives 6 cycles later and value=9'o001.

Source files
------------

// File: rtl/de1_pkg.sv
// Shared types and helpers for the DE1 octal display/entry path.
// Digits are packed little-end first: digit0 = [2:0], digit1 = [5:3], digit2 = [8:6].
package de1_pkg;

    localparam int NUM_DIGITS = 3;

    typedef logic [2:0] octal_digit_t;
    typedef octal_digit_t [NUM_DIGITS-1:0] octal_digits_t;

    function automatic octal_digits_t unpack_octal(input logic [3*NUM_DIGITS-1:0] packed_value);
        octal_digits_t digits;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = packed_value[3*i +: 3];
        end
        return digits;
    endfunction

    function automatic logic [3*NUM_DIGITS-1:0] pack_octal(input octal_digits_t digits);
        logic [3*NUM_DIGITS-1:0] packed_value;
        packed_value = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            packed_value[3*i +: 3] = digits[i];
        end
        return packed_value;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low pushbutton; emits a one-cycle pulse
// when the accepted level goes from released to pressed.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            accepted_q, accepted_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    // Counter only runs while the synchronised level disagrees with the accepted one;
    // any agreement drops it back to zero.
    always_comb begin
        accepted_d = accepted_q;
        cnt_d      = '0;
        press_d    = 1'b0;
        if (sync_q[1] != accepted_q) begin
            if (cnt_q == CntMax) begin
                accepted_d = sync_q[1];
                press_d    = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 2'b11;
            accepted_q <= 1'b1;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], key_ni};
            accepted_q <= accepted_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/octal_key_entry.sv
// Edits a 3-digit octal value from debounced KEY presses and produces a blink
// mask so the display can flash the digit selected for editing.
module octal_key_entry
    import de1_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic       key_sel_n,
    input  logic       load,
    input  logic [8:0] load_value,
    output logic [8:0] value,
    output logic [1:0] sel,
    output logic [2:0] blank_mask,
    output logic       changed
);

    localparam int unsigned BlinkW = $clog2(BLINK_CYCLES);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_CYCLES - 1);

    logic press_inc, press_dec, press_sel;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .key_ni  (key_inc_n),
        .press_o (press_inc)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .key_ni  (key_dec_n),
        .press_o (press_dec)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .key_ni  (key_sel_n),
        .press_o (press_sel)
    );

    logic [8:0]        value_q, value_d;
    logic [1:0]        sel_q, sel_d;
    logic              changed_q;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic              blink_clr;
    octal_digits_t     digits;
    octal_digit_t      delta;

    always_comb begin
        value_d   = value_q;
        sel_d     = sel_q;
        blink_clr = 1'b0;
        digits    = unpack_octal(value_q);
        delta     = press_inc ? 3'd1 : 3'd7;
        if (load) begin
            value_d   = load_value;
            sel_d     = 2'd0;
            blink_clr = 1'b1;
        end else begin
            // Edits act on the old sel, even when a sel event lands in the same cycle.
            if (press_inc ^ press_dec) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q == 2'(i)) begin
                        digits[i] = digits[i] + delta;
                    end
                end
                value_d = pack_octal(digits);
            end
            if (press_sel) begin
                blink_clr = 1'b1;
                case (sel_q)
                    2'd0:    sel_d = 2'd1;
                    2'd1:    sel_d = 2'd2;
                    default: sel_d = 2'd0;
                endcase
            end
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_clr) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            value_q     <= '0;
            sel_q       <= '0;
            changed_q   <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            value_q     <= value_d;
            sel_q       <= sel_d;
            changed_q   <= (value_d != value_q) || (sel_d != sel_q);
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        blank_mask = 3'b000;
        if (phase_q) begin
            case (sel_q)
                2'd0:    blank_mask = 3'b001;
                2'd1:    blank_mask = 3'b010;
                2'd2:    blank_mask = 3'b100;
                default: blank_mask = 3'b000;
            endcase
        end
    end

    assign value   = value_q;
    assign sel     = sel_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_octal_key_entry.sv
// Self-checking bench for octal_key_entry with short debounce/blink periods,
// compared cycle by cycle against an arithmetic reference model.
module tb_octal_key_entry;

    localparam int D = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_n = 1'b1, dec_n = 1'b1, sel_n = 1'b1;
    logic       load = 1'b0;
    logic [8:0] load_value = '0;
    logic [8:0] value;
    logic [1:0] sel;
    logic [2:0] blank_mask;
    logic       changed;

    int checks = 0;
    int errors = 0;

    octal_key_entry #(.DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .key_inc_n  (inc_n),
        .key_dec_n  (dec_n),
        .key_sel_n  (sel_n),
        .load       (load),
        .load_value (load_value),
        .value      (value),
        .sel        (sel),
        .blank_mask (blank_mask),
        .changed    (changed)
    );

    always #10 clk = ~clk;

    // Reference model: digits as integers mod 8, keys as "raw level seen two edges
    // late, accepted after D consecutive disagreeing samples".
    int m_digit[3];
    int m_sel, m_changed, m_since;
    int h1[3], h2[3], run[3], acc[3], pend[3];
    int changed_seen;

    function automatic logic [8:0] m_value();
        return 9'(m_digit[2] * 64 + m_digit[1] * 8 + m_digit[0]);
    endfunction

    function automatic logic [2:0] m_mask();
        if (((m_since / B) % 2) == 1) return 3'(1 << m_sel);
        return 3'b000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_digit[k] = 0; h1[k] = 1; h2[k] = 1; run[k] = 0; acc[k] = 1; pend[k] = 0;
        end
        m_sel = 0; m_changed = 0; m_since = 0;
    endtask

    task automatic model_edge();
        int old_val, old_sel, raw[3];
        bit clr;
        old_val = int'(m_value());
        old_sel = m_sel;
        clr = 1'b0;
        if (load) begin
            for (int k = 0; k < 3; k++) m_digit[k] = int'(load_value[3*k +: 3]);
            m_sel = 0;
            clr = 1'b1;
        end else begin
            if (pend[0] == 1 && pend[1] == 0) m_digit[m_sel] = (m_digit[m_sel] + 1) % 8;
            if (pend[1] == 1 && pend[0] == 0) m_digit[m_sel] = (m_digit[m_sel] + 7) % 8;
            if (pend[2] == 1) begin
                m_sel = (m_sel + 1) % 3;
                clr = 1'b1;
            end
        end
        m_changed = (int'(m_value()) != old_val || m_sel != old_sel) ? 1 : 0;
        m_since = clr ? 0 : m_since + 1;
        raw[0] = int'(inc_n); raw[1] = int'(dec_n); raw[2] = int'(sel_n);
        for (int k = 0; k < 3; k++) begin
            pend[k] = 0;
            if (h2[k] != acc[k]) begin
                run[k]++;
                if (run[k] == D) begin
                    acc[k] = h2[k];
                    run[k] = 0;
                    pend[k] = (h2[k] == 0) ? 1 : 0;
                end
            end else begin
                run[k] = 0;
            end
            h2[k] = h1[k];
            h1[k] = raw[k];
        end
    endtask

    // Advance one clock, update the model and compare every output against it.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (changed === 1'b1) changed_seen++;
        checks++;
        if (value !== m_value()) begin
            errors++;
            $display("FAIL model_value t=%0t got %o want %o", $time, value, m_value());
        end
        checks++;
        if (sel !== 2'(m_sel)) begin
            errors++;
            $display("FAIL model_sel t=%0t got %0d want %0d", $time, sel, m_sel);
        end
        checks++;
        if (blank_mask !== m_mask()) begin
            errors++;
            $display("FAIL model_blank t=%0t got %b want %b", $time, blank_mask, m_mask());
        end
        checks++;
        if (changed !== 1'(m_changed)) begin
            errors++;
            $display("FAIL model_changed t=%0t got %b want %0d", $time, changed, m_changed);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        inc_n = 1'b1; dec_n = 1'b1; sel_n = 1'b1; load = 1'b0;
        rst_n = 1'b0;
        model_reset();
        ticks(3);
        rst_n = 1'b1;
        ticks(2);
    endtask

    // keys: bit0 inc, bit1 dec, bit2 sel
    task automatic press(input logic [2:0] keys, input int hold, input int gap);
        inc_n = ~keys[0]; dec_n = ~keys[1]; sel_n = ~keys[2];
        ticks(hold);
        inc_n = 1'b1; dec_n = 1'b1; sel_n = 1'b1;
        ticks(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (value !== 9'o000 || sel !== 2'd0 || blank_mask !== 3'b000 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%o s=%0d m=%b c=%b want 0", value, sel, blank_mask,
                     changed);
        end
        ticks(2);
        rst_n = 1'b1;
        changed_seen = 0;
        ticks(50);
        checks++;
        if (changed_seen != 0) begin
            errors++;
            $display("FAIL idle_changed got %0d pulses want 0", changed_seen);
        end
        checks++;
        if (value !== 9'o000 || sel !== 2'd0) begin
            errors++;
            $display("FAIL idle_value got %o/%0d want 0/0", value, sel);
        end
    endtask

    task automatic test_inc_bounce();
        do_reset();
        changed_seen = 0;
        inc_n = 1'b0; ticks(3);
        inc_n = 1'b1; ticks(2);
        inc_n = 1'b0; ticks(20);
        inc_n = 1'b1; ticks(10);
        checks++;
        if (value !== 9'o001) begin
            errors++;
            $display("FAIL bounce_single_event got %o want 001", value);
        end
        for (int i = 0; i < 8; i++) press(3'b001, 8, 8);
        checks++;
        if (value !== 9'o001) begin
            errors++;
            $display("FAIL inc_wrap got %o want 001", value);
        end
        checks++;
        if (changed_seen != 9) begin
            errors++;
            $display("FAIL inc_changed_count got %0d want 9", changed_seen);
        end
    endtask

    task automatic test_sel_dec();
        do_reset();
        press(3'b100, 8, 8);
        press(3'b100, 8, 8);
        press(3'b010, 8, 8);
        checks++;
        if (value !== 9'o700 || sel !== 2'd2) begin
            errors++;
            $display("FAIL sel_dec got %o/%0d want 700/2", value, sel);
        end
        press(3'b100, 8, 8);
        checks++;
        if (sel !== 2'd0) begin
            errors++;
            $display("FAIL sel_wrap got %0d want 0", sel);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        load_value = 9'o123; load = 1'b1; tick(); load = 1'b0;
        ticks(2);
        changed_seen = 0;
        press(3'b011, 10, 10);
        checks++;
        if (value !== 9'o123 || changed_seen != 0) begin
            errors++;
            $display("FAIL inc_dec_cancel got %o pulses=%0d want 123 pulses=0", value, changed_seen);
        end
        press(3'b100, 8, 8);
        press(3'b101, 8, 8);
        checks++;
        if (value !== 9'o133 || sel !== 2'd2) begin
            errors++;
            $display("FAIL sel_with_inc got %o/%0d want 133/2", value, sel);
        end
    endtask

    task automatic test_load_blink();
        int guard;
        do_reset();
        inc_n = 1'b0;
        guard = 0;
        while (pend[0] == 0 && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (pend[0] == 0) begin
            errors++;
            $display("FAIL load_wait_event got none after %0d cycles want event", guard);
        end
        load_value = 9'o527; load = 1'b1; tick(); load = 1'b0;
        checks++;
        if (value !== 9'o527 || sel !== 2'd0) begin
            errors++;
            $display("FAIL load_priority got %o/%0d want 527/0", value, sel);
        end
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++;
            if (blank_mask !== ((((i / 8) % 2) == 1) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL blink_pattern cycle=%0d got %b", i, blank_mask);
            end
        end
        inc_n = 1'b1; ticks(10);
        checks++;
        if (value !== 9'o527) begin
            errors++;
            $display("FAIL load_no_repeat got %o want 527", value);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inc_n = 1'b0;
        ticks(4);
        rst_n = 1'b0;
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        ticks(6);
        checks++;
        if (value !== 9'o000) begin
            errors++;
            $display("FAIL reset_mid_early got %o want 000", value);
        end
        tick();
        checks++;
        if (value !== 9'o001) begin
            errors++;
            $display("FAIL reset_mid_event got %o want 001", value);
        end
        ticks(20);
        checks++;
        if (value !== 9'o001) begin
            errors++;
            $display("FAIL reset_mid_single got %o want 001", value);
        end
        inc_n = 1'b1; ticks(8);
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            int hold;
            inc_n = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
            dec_n = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
            sel_n = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
            hold = int'($urandom_range(1, 10));
            for (int c = 0; c < hold; c++) begin
                load = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
                load_value = 9'($urandom);
                tick();
            end
            load = 1'b0;
        end
        inc_n = 1'b1; dec_n = 1'b1; sel_n = 1'b1;
        ticks(10);
    endtask

    initial begin
        model_reset();
        changed_seen = 0;
        test_reset();
        test_inc_bounce();
        test_sel_dec();
        test_simultaneous();
        test_load_blink();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
